spi_slave_fifo: RTL

SPI slave (responder) core that sits on the far side of the team's SPI master: it accepts SPI_CLK, SPI_CS_N and SPI_MOSI from an external master, shifts bytes in and out, and buffers them in TX and RX byte FIFOs on the fabric side. It supports all four CPOL/CPHA modes. It runs entirely in the system clock domain by oversampling the synchronized SPI pins. Its first use is as a loopback responder for master bring-up and sensor emulation; an AXI wrapper may sit on top later.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_fwft_fifo.sv | 52 +++++
 rtl/spi_slave_fifo.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states, idle fill byte and mode encodings.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } spi_state_t;

  localparam logic [7:0] IDLE_BYTE = 8'hFF;

  // Mode encoding is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

endpackage

// File: rtl/spi_fwft_fifo.sv
// Synchronous first-word fall-through FIFO; head reads as zero while empty.
module spi_fwft_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write at full still lands
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI slave with TX/RX byte FIFOs, all four CPOL/CPHA modes, oversampled in
// the system clock domain.
module spi_slave_fifo
  import spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       SPI_CLK,
  input  logic       SPI_CS_N,
  input  logic       SPI_MOSI,
  output logic       SPI_MISO,
  output logic       o_MISO_OE,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_Wr_En,
  output logic       o_TX_Full,
  output logic [7:0] o_RX_Byte,
  input  logic       i_RX_Rd_En,
  output logic       o_RX_Empty,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic       o_RX_Overflow,
  output logic       o_TX_Underrun,
  input  logic       i_Clr_Err
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_q, cs_q;
  logic       sclk_s, cs_s, mosi_s;
  spi_state_t state, state_d;
  logic       cpol_q, cpha_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       lead, trail, in_frame, sample_evt, shift_evt, cs_fall;
  logic       tx_pop, rx_push, tx_empty, rx_full;
  logic [7:0] tx_head, peek;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_CLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS_N};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign cs_fall    = cs_q && !cs_s;
  assign lead       = cpol_q ? (sclk_q && !sclk_s) : (!sclk_q && sclk_s);
  assign trail      = cpol_q ? (!sclk_q && sclk_s) : (sclk_q && !sclk_s);
  assign in_frame   = (state == ST_ACTIVE) && !cs_s;
  assign sample_evt = in_frame && (cpha_q ? trail : lead);
  assign shift_evt  = in_frame && (cpha_q ? lead : trail);
  assign tx_pop     = sample_evt && (bit_cnt == 3'd0);
  assign rx_push    = sample_evt && (bit_cnt == 3'd7);
  assign peek       = tx_empty ? IDLE_BYTE : tx_head;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_s)    state_d = ST_END;
      ST_END:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign o_Busy       = (state == ST_ACTIVE);
  assign o_Frame_Done = (state == ST_END);
  assign o_MISO_OE    = !cs_s;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= IDLE_BYTE;
      SPI_MISO      <= 1'b1;
      o_RX_Overflow <= 1'b0;
      o_TX_Underrun <= 1'b0;
    end else begin
      if (state == ST_IDLE && cs_fall) begin
        cpol_q  <= CPOL;
        cpha_q  <= CPHA;
        bit_cnt <= '0;
        if (!CPHA) SPI_MISO <= peek[7];
      end
      if (sample_evt) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= {rx_shift[5:0], mosi_s};
        if (tx_pop) tx_shift <= peek;
      end
      // Byte boundary shows the not-yet-committed head so no pop happens
      // unless another sample edge follows
      if (shift_evt)
        SPI_MISO <= (bit_cnt == 3'd0) ? peek[7] : tx_shift[3'd7 - bit_cnt];
      if (state == ST_END) begin
        bit_cnt  <= '0;
        SPI_MISO <= 1'b1;
      end
      if (i_Clr_Err) begin
        o_RX_Overflow <= 1'b0;
        o_TX_Underrun <= 1'b0;
      end else begin
        if (rx_push && rx_full && !i_RX_Rd_En) o_RX_Overflow <= 1'b1;
        if (tx_pop && tx_empty)                o_TX_Underrun <= 1'b1;
      end
    end
  end

  spi_fwft_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .wr_en   (i_TX_Wr_En),
    .wr_data (i_TX_Byte),
    .rd_en   (tx_pop),
    .rd_data (tx_head),
    .full    (o_TX_Full),
    .empty   (tx_empty)
  );

  spi_fwft_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk     (i_Clk),
    .rst_n   (i_Rst_L),
    .wr_en   (rx_push),
    .wr_data ({rx_shift, mosi_s}),
    .rd_en   (i_RX_Rd_En),
    .rd_data (o_RX_Byte),
    .full    (rx_full),
    .empty   (o_RX_Empty)
  );

endmodule
